// File: rtl/vehicle_ctrl_pkg.sv
// ============================================================================
// vehicle_ctrl_pkg : shared alarm state encoding and position/speed limits
// Revision: 1.0
// ============================================================================
`default_nettype none

package vehicle_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON_HI = 2'd1,
    ON_LO = 2'd2
  } alarm_state_t;

  localparam logic [2:0] POS_MIN    = 3'd0;
  localparam logic [2:0] POS_CENTER = 3'd3;
  localparam logic [2:0] POS_MAX    = 3'd6;
  localparam logic [1:0] SPEED_MIN  = 2'd0;
  localparam logic [1:0] SPEED_MAX  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/vehicle_ctrl_rise_detect.sv
// ============================================================================
// rise_detect : 1-bit rising-edge detector with a previous-sample register
// Revision: 1.0
// ============================================================================
`default_nettype none

module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= d;
  end

  // Event is consumed by the FSMs at the same edge that samples d high
  assign rise = d & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/vehicle_ctrl.sv
// ============================================================================
// vehicle_ctrl : alarm blinker, lateral position and speed level FSMs
// Revision: 1.0
// ============================================================================
`default_nettype none

module vehicle_ctrl
  import vehicle_ctrl_pkg::*;
#(
  parameter int BLINK_HALF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       l_in,
  input  logic       r_in,
  input  logic       b_in,
  input  logic       f_in,
  output logic       alarm_y,
  output logic [2:0] move_state,
  output logic [1:0] engine_state
);

  localparam logic [7:0] c_HALF_LAST = 8'(BLINK_HALF - 1);

  logic w_l_ev, w_r_ev, w_b_ev, w_f_ev;

  rise_detect u_rd_l (.clk(clk), .rst_n(reset), .d(l_in), .rise(w_l_ev));
  rise_detect u_rd_r (.clk(clk), .rst_n(reset), .d(r_in), .rise(w_r_ev));
  rise_detect u_rd_b (.clk(clk), .rst_n(reset), .d(b_in), .rise(w_b_ev));
  rise_detect u_rd_f (.clk(clk), .rst_n(reset), .d(f_in), .rise(w_f_ev));

  // ---------------- alarm FSM ----------------
  alarm_state_t r_alarm_state, w_alarm_next;
  logic [7:0]   r_blink_cnt, w_blink_cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alarm_state <= OFF;
      r_blink_cnt   <= 8'd0;
      alarm_y       <= 1'b0;
    end else begin
      r_alarm_state <= w_alarm_next;
      r_blink_cnt   <= w_blink_cnt_next;
      alarm_y       <= (w_alarm_next == ON_HI);
    end
  end

  always_comb begin
    w_alarm_next     = r_alarm_state;
    w_blink_cnt_next = r_blink_cnt;
    if (!a) begin
      w_alarm_next     = OFF;
      w_blink_cnt_next = 8'd0;
    end else begin
      case (r_alarm_state)
        OFF: begin
          w_alarm_next     = ON_HI;
          w_blink_cnt_next = 8'd0;
        end
        ON_HI: begin
          if (r_blink_cnt == c_HALF_LAST) begin
            w_alarm_next     = ON_LO;
            w_blink_cnt_next = 8'd0;
          end else begin
            w_blink_cnt_next = r_blink_cnt + 8'd1;
          end
        end
        ON_LO: begin
          if (r_blink_cnt == c_HALF_LAST) begin
            w_alarm_next     = ON_HI;
            w_blink_cnt_next = 8'd0;
          end else begin
            w_blink_cnt_next = r_blink_cnt + 8'd1;
          end
        end
        default: begin
          w_alarm_next     = OFF;
          w_blink_cnt_next = 8'd0;
        end
      endcase
    end
  end

  // ---------------- movement FSM ----------------
  logic [2:0] w_move_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) move_state <= POS_CENTER;
    else        move_state <= w_move_next;
  end

  always_comb begin
    w_move_next = move_state;
    if (move_state > POS_MAX) begin
      w_move_next = POS_CENTER;
    end else if (w_l_ev && !w_r_ev) begin
      if (move_state != POS_MIN) w_move_next = move_state - 3'd1;
    end else if (w_r_ev && !w_l_ev) begin
      if (move_state != POS_MAX) w_move_next = move_state + 3'd1;
    end
  end

  // ---------------- engine FSM ----------------
  logic [1:0] w_engine_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) engine_state <= SPEED_MIN;
    else        engine_state <= w_engine_next;
  end

  // Brake wins over a simultaneous forward event
  always_comb begin
    w_engine_next = engine_state;
    if (w_b_ev) begin
      if (engine_state != SPEED_MIN) w_engine_next = engine_state - 2'd1;
    end else if (w_f_ev) begin
      if (engine_state != SPEED_MAX) w_engine_next = engine_state + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vehicle_ctrl.sv
// ============================================================================
// tb_vehicle_ctrl : table-driven vectors plus an async-reset sequence
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vehicle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a = 1'b0, l_in = 1'b0, r_in = 1'b0, b_in = 1'b0, f_in = 1'b0;
  logic       alarm_y;
  logic [2:0] move_state;
  logic [1:0] engine_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vehicle_ctrl #(.BLINK_HALF(1)) dut (
    .clk(clk), .reset(reset), .a(a), .l_in(l_in), .r_in(r_in),
    .b_in(b_in), .f_in(f_in), .alarm_y(alarm_y),
    .move_state(move_state), .engine_state(engine_state)
  );

  typedef struct {
    logic       a, l, r, b, f;
    logic       ey;
    logic [2:0] em;
    logic [1:0] ee;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic va, vl, vr, vb, vf,
                              input logic ey, input logic [2:0] em,
                              input logic [1:0] ee);
    vec_t v;
    v.a = va; v.l = vl; v.r = vr; v.b = vb; v.f = vf;
    v.ey = ey; v.em = em; v.ee = ee;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic ey,
                         input logic [2:0] em, input logic [1:0] ee);
    chk({nm, ".alarm_y"}, idx, {7'd0, alarm_y}, {7'd0, ey});
    chk({nm, ".move"}, idx, {5'd0, move_state}, {5'd0, em});
    chk({nm, ".engine"}, idx, {6'd0, engine_state}, {6'd0, ee});
  endtask

  initial begin
    // idle after reset release
    for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,3,0);
    // alarm blinking, starts at 1, then drops on a=0
    for (int i = 0; i < 10; i++) add(1,0,0,0,0, (i % 2) == 0, 3, 0);
    add(0,0,0,0,0, 0,3,0);
    add(0,0,0,0,0, 0,3,0);
    // four left pulses: 2,1,0,0
    add(0,1,0,0,0, 0,2,0); add(0,0,0,0,0, 0,2,0);
    add(0,1,0,0,0, 0,1,0); add(0,0,0,0,0, 0,1,0);
    add(0,1,0,0,0, 0,0,0); add(0,0,0,0,0, 0,0,0);
    add(0,1,0,0,0, 0,0,0); add(0,0,0,0,0, 0,0,0);
    // seven right pulses: 1..6,6
    for (int i = 1; i <= 7; i++) begin
      add(0,0,1,0,0, 0, 3'((i > 6) ? 6 : i), 0);
      add(0,0,0,0,0, 0, 3'((i > 6) ? 6 : i), 0);
    end
    // brake at zero, then forward 1,2,3,3
    for (int i = 0; i < 2; i++) begin
      add(0,0,0,1,0, 0,6,0); add(0,0,0,0,0, 0,6,0);
    end
    for (int i = 1; i <= 4; i++) begin
      add(0,0,0,0,1, 0,6, 2'((i > 3) ? 3 : i));
      add(0,0,0,0,0, 0,6, 2'((i > 3) ? 3 : i));
    end
    // brake and forward together at max: brake only
    add(0,0,0,1,1, 0,6,2); add(0,0,0,0,0, 0,6,2);
    // back to centre
    add(0,1,0,0,0, 0,5,2); add(0,0,0,0,0, 0,5,2);
    add(0,1,0,0,0, 0,4,2); add(0,0,0,0,0, 0,4,2);
    add(0,1,0,0,0, 0,3,2); add(0,0,0,0,0, 0,3,2);
    // held left gives one step only
    for (int i = 0; i < 6; i++) add(0,1,0,0,0, 0,2,2);
    add(0,0,0,0,0, 0,2,2); add(0,0,0,0,0, 0,2,2);
    // simultaneous left and right: hold
    add(0,1,1,0,0, 0,2,2); add(0,0,0,0,0, 0,2,2);
    // set up move=5, engine=2, alarm blinking
    add(1,0,1,0,0, 1,3,2); add(1,0,0,0,0, 0,3,2);
    add(1,0,1,0,0, 1,4,2); add(1,0,0,0,0, 0,4,2);
    add(1,0,1,0,0, 1,5,2); add(1,0,0,0,0, 0,5,2);
    add(1,0,0,0,0, 1,5,2);

    // reset held: outputs at reset values
    repeat (2) @(posedge clk);
    #1 chk_all("reset_hold", 0, 1'b0, 3'd3, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      a = vecs[i].a; l_in = vecs[i].l; r_in = vecs[i].r;
      b_in = vecs[i].b; f_in = vecs[i].f;
      @(posedge clk);
      #1 chk_all("vec", i, vecs[i].ey, vecs[i].em, vecs[i].ee);
      @(negedge clk);
    end

    // asynchronous reset mid-cycle with alarm high, move=5, engine=2
    #2 reset = 1'b0;
    #1 chk_all("async_reset", 0, 1'b0, 3'd3, 2'd0);
    l_in = 1'b1; f_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 chk_all("reset_held", i, 1'b0, 3'd3, 2'd0);
    end
    // inputs already high at release produce events on the first edge
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk_all("post_reset", 0, 1'b1, 3'd2, 2'd1);
    @(posedge clk);
    #1 chk_all("post_reset", 1, 1'b0, 3'd2, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
